apb_timer_slave: RTL and testbench
==================================

Name: apb_timer_slave

Overview:
- APB completer that sits directly downstream of Bridge_Top; the top connects one bit of Pselx to this block's Psel.
- Provides a memory-mapped, prescaled down-counter timer with interrupt, plus a sticky APB protocol-violation monitor.
- Bridge_Top has no PREADY or PSLVERR, so every access completes with zero wait states.
- Read data is registered in the SETUP cycle so it is stable for the whole ACCESS cycle.

Parameters:
- ID_VALUE, 32'h5449_4D31, constant returned by the ID register.
- PRESC_W, 8, width of the prescale register and the prescale counter.

Ports:
- Pclk  in  1  APB clock; all flops use its rising edge.
- Presetn  in  1  asynchronous active-low reset.
- Psel  in  1  select for this completer (one bit of Pselx).
- Penable  in  1  APB enable.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  address; only Paddr[7:2] is decoded.
- Pwdata  in  32  write data.
- Prdata  out  32  read data.
- irq  out  1  level interrupt, equal to STATUS.expired AND CTRL.irq_en.

Behaviour:
- Reset, asynchronous on Presetn low:
  - Prdata=0, irq=0.
  - CTRL=0, LOAD=0, COUNT=0, STATUS=0, PRESCALE=0, prescale counter=0.
  - Monitor FSM returns to IDLE.
- Register map by Paddr[7:2]; Paddr[31:8] and Paddr[1:0] are ignored:
  - 0x00 CTRL (RW): bit0 en, bit1 auto_reload, bit2 irq_en; bits 31:3 read as 0.
  - 0x04 LOAD (RW, 32 bit).
  - 0x08 COUNT (RO).
  - 0x0C STATUS (W1C): bit0 expired, bit1 perr.
  - 0x10 PRESCALE (RW, PRESC_W bits).
  - 0x14 ID (RO).
  - Unmapped offsets read 0; writes to them are ignored.
- Read timing:
  - On a rising edge with Psel=1, Penable=0, Pwrite=0: Prdata <= decoded register value.
  - Prdata holds that value until the next read SETUP. This gives 1-cycle latency, and the value is valid throughout ACCESS.
- Write timing:
  - A write commits on a rising edge with Psel=1, Penable=1, Pwrite=1.
  - Writes to RO registers have no effect.
  - Writing LOAD also sets COUNT=Pwdata and clears the prescale counter.
- Prescaler:
  - While en=1, the prescale counter increments each cycle.
  - When it equals PRESCALE, it wraps to 0 and asserts a one-cycle internal tick. PRESCALE=0 therefore ticks every cycle.
  - While en=0, the counter holds at 0.
- Count behaviour on each tick:
  - COUNT>1: decrement.
  - COUNT==1: set expired. If auto_reload=1, COUNT<=LOAD; otherwise COUNT<=0.
  - COUNT==0 and auto_reload=0: hold at 0; no further expiry.
  - COUNT==0 and auto_reload=1: COUNT<=LOAD; no expiry.
- Simultaneous events:
  - LOAD write and tick in the same cycle: the write wins and that tick is discarded.
  - Hardware set of expired/perr and a W1C of the same bit in the same cycle: the set wins, and the bit stays 1.
  - CTRL write clearing en: takes effect on the next cycle; a tick coincident with the write still applies.
- Protocol monitor FSM:
  - IDLE: Psel=1 & Penable=0 -> SETUP; Penable=1 -> perr, stay in IDLE.
  - SETUP: latch Paddr and Pwrite.
    - Psel=1 & Penable=1 -> ACCESS.
    - Psel=0 -> perr, go to IDLE.
    - Psel=1 & Penable=0 -> perr, stay in SETUP.
  - In ACCESS, if Paddr or Pwrite differs from the latched value: set perr; the write still commits.
  - ACCESS -> SETUP if Psel=1 & Penable=0 (back-to-back transfer); otherwise -> IDLE.
  - perr is sticky until W1C.
- Reset mid-transfer: the transfer is abandoned, the FSM goes to IDLE, and no write commits.

Decomposition:
- Shared package apb_timer_pkg holds:
  - register offset localparams;
  - CTRL and STATUS bit-index constants;
  - the monitor state enum typedef (IDLE, SETUP, ACCESS);
  - the default ID constant.
- One sub-module, apb_prot_mon: the monitor FSM. Its output is a one-cycle perr_set pulse.
- Register file and timer stay in apb_timer_slave.

Test Plan:
- Reset then read ID at Paddr 0x8000_0014 -> Prdata=32'h5449_4D31 during ACCESS; irq=0.
- Write LOAD=3, PRESCALE=1, CTRL=3'b101 -> COUNT steps 3,2,1,0, one step every 2 cycles; expired=1 and irq=1 after 6 cycles; COUNT holds at 0.
- LOAD=2, PRESCALE=0, CTRL=3'b111 -> COUNT sequence 2,1,2,1…; expired set at the first wrap. Write STATUS=1 in the same cycle as the next expiry -> expired stays 1.
- Back-to-back writes to offsets 0x04, 0x55 and 0x66 with no IDLE cycle between them -> LOAD=value, 0x55 decodes as 0x54 (unmapped, ignored), perr stays 0.
- Drive Penable=1 with no SETUP cycle, then change Paddr between SETUP and ACCESS -> STATUS reads 32'h2; write STATUS=2 -> reads 0.
- Assert Presetn low during an ACCESS write to LOAD -> LOAD=0, Prdata=0, FSM IDLE after release.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// Shared constants and types for the APB timer completer.
// Register offsets, field bit positions and monitor states.
package apb_timer_pkg;

  localparam logic [31:0] ID_DEFAULT = 32'h5449_4D31;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_LOAD   = 8'h04;
  localparam logic [7:0] OFF_COUNT  = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_PRESC  = 8'h10;
  localparam logic [7:0] OFF_ID     = 8'h14;

  localparam logic [5:0] IDX_CTRL   = OFF_CTRL[7:2];
  localparam logic [5:0] IDX_LOAD   = OFF_LOAD[7:2];
  localparam logic [5:0] IDX_COUNT  = OFF_COUNT[7:2];
  localparam logic [5:0] IDX_STATUS = OFF_STATUS[7:2];
  localparam logic [5:0] IDX_PRESC  = OFF_PRESC[7:2];
  localparam logic [5:0] IDX_ID     = OFF_ID[7:2];

  localparam int CTRL_EN  = 0;
  localparam int CTRL_AR  = 1;
  localparam int CTRL_IRQ = 2;

  localparam int ST_EXP  = 0;
  localparam int ST_PERR = 1;

  typedef enum logic [1:0] {
    MON_IDLE,
    MON_SETUP,
    MON_ACCESS
  } mon_state_e;

endpackage

// File: rtl/apb_prot_mon.sv
// APB protocol monitor: tracks transfer phases and
// pulses perr_set_o for one cycle on any violation.
module apb_prot_mon
  import apb_timer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  output logic        perr_set_o
);

  mon_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;

  // State and latched SETUP attributes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MON_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
  end

  // Phase transitions; SETUP cycles re-latch address and direction
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    perr_set_o = 1'b0;
    unique case (state_q)
      MON_IDLE: begin
        if (psel_i && !penable_i) begin
          state_d = MON_SETUP;
          addr_d  = paddr_i;
          wr_d    = pwrite_i;
        end else if (penable_i) begin
          perr_set_o = 1'b1;
        end
      end
      MON_SETUP: begin
        if (!psel_i) begin
          perr_set_o = 1'b1;
          state_d    = MON_IDLE;
        end else if (penable_i) begin
          state_d = MON_ACCESS;
          if ((paddr_i != addr_q) || (pwrite_i != wr_q))
            perr_set_o = 1'b1;
        end else begin
          perr_set_o = 1'b1;
          addr_d     = paddr_i;
          wr_d       = pwrite_i;
        end
      end
      MON_ACCESS: begin
        if (psel_i && !penable_i) begin
          state_d = MON_SETUP;
          addr_d  = paddr_i;
          wr_d    = pwrite_i;
        end else begin
          state_d = MON_IDLE;
        end
      end
      default: state_d = MON_IDLE;
    endcase
  end

endmodule

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB completer with a prescaled
// down-counter timer, interrupt and sticky protocol error flag.
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = ID_DEFAULT,
  parameter int          PRESC_W  = 8
) (
  input  logic        Pclk,
  input  logic        Presetn,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        irq
);

  logic [5:0]         idx;
  logic               rd_setup, wr_acc;
  logic               wr_ctrl, wr_load, wr_stat, wr_presc;
  logic               tick, exp_set, perr_set;
  logic [31:0]        rdata;

  logic [2:0]         ctrl_q, ctrl_d;
  logic [31:0]        load_q, load_d;
  logic [31:0]        count_q, count_d;
  logic [1:0]         stat_q, stat_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]        prdata_q, prdata_d;

  assign idx      = Paddr[7:2];
  assign rd_setup = Psel && !Penable && !Pwrite;
  assign wr_acc   = Psel && Penable && Pwrite;
  assign wr_ctrl  = wr_acc && (idx == IDX_CTRL);
  assign wr_load  = wr_acc && (idx == IDX_LOAD);
  assign wr_stat  = wr_acc && (idx == IDX_STATUS);
  assign wr_presc = wr_acc && (idx == IDX_PRESC);
  assign tick     = ctrl_q[CTRL_EN] && (pcnt_q == presc_q);

  apb_prot_mon u_mon (
    .clk_i      (Pclk),
    .rst_ni     (Presetn),
    .psel_i     (Psel),
    .penable_i  (Penable),
    .pwrite_i   (Pwrite),
    .paddr_i    (Paddr),
    .perr_set_o (perr_set)
  );

  // Read-back mux over the decoded word offset
  always_comb begin
    rdata = '0;
    unique case (idx)
      IDX_CTRL:   rdata = {29'd0, ctrl_q};
      IDX_LOAD:   rdata = load_q;
      IDX_COUNT:  rdata = count_q;
      IDX_STATUS: rdata = {30'd0, stat_q};
      IDX_PRESC:  rdata = 32'(presc_q);
      IDX_ID:     rdata = ID_VALUE;
      default:    rdata = '0;
    endcase
  end

  // Register writes, prescaler, count and status next state
  always_comb begin
    ctrl_d   = ctrl_q;
    load_d   = load_q;
    presc_d  = presc_q;
    count_d  = count_q;
    pcnt_d   = pcnt_q;
    stat_d   = stat_q;
    exp_set  = 1'b0;
    prdata_d = rd_setup ? rdata : prdata_q;

    if (!ctrl_q[CTRL_EN] || tick) pcnt_d = '0;
    else                          pcnt_d = pcnt_q + 1'b1;

    if (tick) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else begin
        exp_set = (count_q == 32'd1);
        count_d = ctrl_q[CTRL_AR] ? load_q : 32'd0;
      end
    end

    // A LOAD write overrides any coincident tick
    if (wr_load) begin
      load_d  = Pwdata;
      count_d = Pwdata;
      pcnt_d  = '0;
      exp_set = 1'b0;
    end
    if (wr_ctrl)  ctrl_d  = Pwdata[2:0];
    if (wr_presc) presc_d = Pwdata[PRESC_W-1:0];

    // Hardware set takes precedence over W1C
    if (wr_stat) stat_d = stat_q & ~Pwdata[1:0];
    if (exp_set)  stat_d[ST_EXP]  = 1'b1;
    if (perr_set) stat_d[ST_PERR] = 1'b1;
  end

  // State registers
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      ctrl_q   <= '0;
      load_q   <= '0;
      count_q  <= '0;
      stat_q   <= '0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      prdata_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      load_q   <= load_d;
      count_q  <= count_d;
      stat_q   <= stat_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      prdata_q <= prdata_d;
    end
  end

  assign Prdata = prdata_q;
  assign irq    = stat_q[ST_EXP] && ctrl_q[CTRL_IRQ];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Testbench for apb_timer_slave: directed scenarios plus
// randomized APB traffic against a behavioural model.
module tb_apb_timer_slave;

  logic        Pclk = 1'b0;
  logic        Presetn = 1'b0;
  logic        Psel = 1'b0;
  logic        Penable = 1'b0;
  logic        Pwrite = 1'b0;
  logic [31:0] Paddr = '0;
  logic [31:0] Pwdata = '0;
  logic [31:0] Prdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 Pclk = ~Pclk;

  apb_timer_slave dut (
    .Pclk    (Pclk),
    .Presetn (Presetn),
    .Psel    (Psel),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Prdata  (Prdata),
    .irq     (irq)
  );

  // Behavioural model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_load, m_count, m_prdata;
  logic [7:0]  m_presc, m_psc;
  logic        m_exp, m_perr;
  logic        viol = 1'b0;

  function automatic logic [31:0] m_read(input logic [5:0] w);
    case (w)
      6'd0:    return {29'd0, m_ctrl};
      6'd1:    return m_load;
      6'd2:    return m_count;
      6'd3:    return {30'd0, m_perr, m_exp};
      6'd4:    return {24'd0, m_presc};
      6'd5:    return 32'h5449_4D31;
      default: return 32'd0;
    endcase
  endfunction

  // Model: timer period is PRESCALE+1 cycles while enabled
  always @(posedge Pclk or negedge Presetn) begin : model
    logic [5:0]  w;
    logic        wr, tk, fire;
    logic [31:0] nxt;
    if (!Presetn) begin
      m_ctrl = 0; m_load = 0; m_count = 0; m_prdata = 0;
      m_presc = 0; m_psc = 0; m_exp = 0; m_perr = 0;
    end else begin
      w  = Paddr[7:2];
      wr = Psel && Penable && Pwrite;
      if (Psel && !Penable && !Pwrite) m_prdata = m_read(w);
      tk   = m_ctrl[0] && (m_psc == m_presc);
      fire = 1'b0;
      nxt  = m_count;
      if (tk) begin
        if (m_count > 1) nxt = m_count - 1;
        else begin
          fire = (m_count == 1);
          nxt  = m_ctrl[1] ? m_load : 32'd0;
        end
      end
      m_psc = (!m_ctrl[0] || tk) ? 8'd0 : m_psc + 8'd1;
      if (wr && w == 6'd1) begin
        nxt = Pwdata; m_psc = 0; fire = 1'b0; m_load = Pwdata;
      end
      m_count = nxt;
      if (wr && w == 6'd3) begin
        if (Pwdata[0]) m_exp = 1'b0;
        if (Pwdata[1]) m_perr = 1'b0;
      end
      if (fire) m_exp = 1'b1;
      if (viol) m_perr = 1'b1;
      if (wr && w == 6'd0) m_ctrl = Pwdata[2:0];
      if (wr && w == 6'd4) m_presc = Pwdata[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Pclk);
      Psel = 0; Penable = 0; Pwrite = 0;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge Pclk);
    Psel = 1; Penable = 0; Pwrite = 1; Paddr = a; Pwdata = d;
    @(negedge Pclk);
    Penable = 1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge Pclk);
    Psel = 1; Penable = 0; Pwrite = 0; Paddr = a;
    @(negedge Pclk);
    Penable = 1;
    d = Prdata;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, v, a;
    int          k;

    // Reset
    repeat (2) @(negedge Pclk);
    chk("rst_prdata", Prdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    Presetn = 1;

    // ID read with high address bits set
    rd(32'h8000_0014, d);
    chk("id", d, 32'h5449_4D31);
    chk("id_irq", {31'd0, irq}, 32'd0);
    idle(1);

    // One-shot, prescale 1
    wr(32'h04, 32'd3);
    wr(32'h10, 32'd1);
    wr(32'h00, 32'd5);
    for (int i = 0; i < 8; i++) begin
      @(negedge Pclk);
      Psel = 0; Penable = 0; Pwrite = 0;
      chk($sformatf("oneshot_irq%0d", i), {31'd0, irq},
          {31'd0, (i >= 6)});
      chk("oneshot_irq_m", {31'd0, irq}, {31'd0, m_exp & m_ctrl[2]});
    end
    rd(32'h08, d);
    chk("oneshot_count", d, 32'd0);
    rd(32'h0C, d);
    chk("oneshot_status", d, 32'd1);

    // Auto-reload, prescale 0, W1C coincident with expiry
    wr(32'h00, 32'd0);
    wr(32'h0C, 32'd1);
    wr(32'h04, 32'd2);
    wr(32'h10, 32'd0);
    wr(32'h00, 32'd7);
    idle(2);
    wr(32'h0C, 32'd1);
    rd(32'h0C, d);
    chk("w1c_set_wins", d, 32'd1);
    chk("w1c_set_wins_m", d, m_prdata);
    rd(32'h08, d);
    chk("reload_count_m", d, m_prdata);
    wr(32'h00, 32'd0);
    wr(32'h0C, 32'd3);

    // Back-to-back writes incl. unmapped offsets
    v = 32'hC0DE_1234;
    wr(32'h04, v);
    wr(32'h55, 32'hFFFF_FFFF);
    wr(32'h66, 32'h1111_1111);
    idle(1);
    rd(32'h04, d);
    chk("b2b_load", d, v);
    rd(32'h54, d);
    chk("b2b_unmapped", d, 32'd0);
    rd(32'h0C, d);
    chk("b2b_no_perr", d, 32'd0);
    idle(1);

    // Penable without SETUP
    @(negedge Pclk);
    Psel = 1; Penable = 1; Pwrite = 0; Paddr = 32'h0; viol = 1;
    @(negedge Pclk);
    Psel = 0; Penable = 0; viol = 0;
    rd(32'h0C, d);
    chk("perr_noset", d, 32'd2);
    wr(32'h0C, 32'd2);
    rd(32'h0C, d);
    chk("perr_clr1", d, 32'd0);
    idle(1);

    // Address change between SETUP and ACCESS
    @(negedge Pclk);
    Psel = 1; Penable = 0; Pwrite = 0; Paddr = 32'h0C;
    @(negedge Pclk);
    Penable = 1; Paddr = 32'h08; viol = 1;
    @(negedge Pclk);
    Psel = 0; Penable = 0; viol = 0;
    rd(32'h0C, d);
    chk("perr_addr", d, 32'd2);
    chk("perr_addr_m", d, m_prdata);
    wr(32'h0C, 32'd2);
    rd(32'h0C, d);
    chk("perr_clr2", d, 32'd0);

    // Reset during ACCESS of a LOAD write
    @(negedge Pclk);
    Psel = 1; Penable = 0; Pwrite = 1; Paddr = 32'h04;
    Pwdata = 32'h0000_ABCD;
    @(negedge Pclk);
    Penable = 1;
    #2 Presetn = 0;
    @(negedge Pclk);
    Psel = 0; Penable = 0; Pwrite = 0;
    chk("rst_mid_prdata", Prdata, 32'd0);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    @(negedge Pclk);
    Presetn = 1;
    rd(32'h04, d);
    chk("rst_mid_load", d, 32'd0);
    rd(32'h0C, d);
    chk("rst_mid_status", d, 32'd0);

    // Randomized legal traffic against the model
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 7);
      a = {$urandom_range(0, 255), 22'd0, k[5:0], 2'b00}
          | 32'($urandom_range(0, 3));
      a[31:8] = 24'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        case (k)
          0: v = $urandom;
          1: v = 32'($urandom_range(0, 12));
          4: v = 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF_FF00);
          default: v = $urandom;
        endcase
        wr(a, v);
      end else begin
        rd(a, d);
        chk($sformatf("rand_rd%0d_off%0d", i, k), d, m_prdata);
        chk("rand_irq", {31'd0, irq}, {31'd0, m_exp & m_ctrl[2]});
      end
      idle($urandom_range(0, 3));
    end
    rd(32'h08, d);
    chk("final_count", d, m_prdata);
    rd(32'h0C, d);
    chk("final_status", d, m_prdata);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
